// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cond_pkg (package)
//  Purpose : Shared types and constants for the conditional-execution stage.
//            - cond_e  : ARM condition-field encodings
//            - flags_t : packed {N,Z,C,V} flag vector
//            - *_BIT   : bit positions of each flag inside flags_t
//  Revision: 1.0 - initial release
// ============================================================================
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef logic [3:0] flags_t;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/condcheck.sv
`default_nettype none
// ============================================================================
//  Module  : condcheck
//  Purpose : Purely combinational evaluation of an ARM condition field
//            against a {N,Z,C,V} flag vector.
//  Ports   : i_cond  [3:0] condition field
//            i_flags [3:0] flags to test, {N,Z,C,V}
//            o_pass        1 when the condition holds
//  Revision: 1.0 - initial release
// ============================================================================
module condcheck
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  flags_t     i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[N_BIT];
    assign w_z  = i_flags[Z_BIT];
    assign w_c  = i_flags[C_BIT];
    assign w_v  = i_flags[V_BIT];
    // Signed greater-or-equal: N matches V when no signed overflow flipped the sign.
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = w_ge;
            COND_LT: o_pass = ~w_ge;
            COND_GT: o_pass = ~w_z & w_ge;
            COND_LE: o_pass = w_z | ~w_ge;
            COND_AL: o_pass = 1'b1;
            // Reserved encoding never executes.
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule : condcheck
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
//  Module  : cond_logic
//  Purpose : Conditional-execution stage. Holds the architectural NZCV flag
//            register, evaluates Cond against the stored flags (condcheck),
//            gates the PC / register / memory write enables and commits new
//            ALU flags under FlagW control with stall and flush support.
//  Ports   : clk, rst_n (async, active-low)
//            InstrValid, Stall, Flush        - pipeline control
//            Cond[3:0], ALUFlags[3:0], FlagW[1:0]
//            PCS, RegW, MemW, NoWrite        - ungated enables from decode
//            PCSrc, RegWrite, MemWrite       - gated enables
//            CondEx                          - live instruction passed its condition
//            Flags[3:0]                      - stored {N,Z,C,V}
//            exec_cnt, squash_cnt [STAT_W]   - only with COND_STATS_EN
//  Config  : `define COND_STATS_EN adds saturating execute/squash counters.
//  Revision: 1.0 - initial release
// ============================================================================
module cond_logic
    import cond_pkg::*;
#(
    parameter int STAT_W = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InstrValid,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic [3:0]        Flags
`ifdef COND_STATS_EN
    ,
    output logic [STAT_W-1:0] exec_cnt,
    output logic [STAT_W-1:0] squash_cnt
`endif
);

    if (STAT_W < 1) begin : g_stat_w_check
        $error("cond_logic: STAT_W must be at least 1");
    end

    flags_t r_flags;
    logic   w_live;
    logic   w_pass;
    logic   w_condex;
    logic   w_commit;

    // Condition is always tested against the stored flags, never the
    // in-flight ALU result, so evaluation needs no bypass path.
    condcheck u_condcheck (
        .i_cond  (Cond),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    assign w_live   = InstrValid & ~Flush;
    assign w_condex = w_live & w_pass;
    // Stall freezes state but leaves the combinational outputs untouched.
    assign w_commit = ~Stall & w_condex;

    assign CondEx   = w_condex;
    assign PCSrc    = PCS & w_condex;
    assign RegWrite = RegW & ~NoWrite & w_condex;
    assign MemWrite = MemW & w_condex;
    assign Flags    = r_flags;

    // N,Z and C,V are written independently so logical ops can leave C,V alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_commit) begin
            if (FlagW[1]) begin
                r_flags[N_BIT] <= ALUFlags[N_BIT];
                r_flags[Z_BIT] <= ALUFlags[Z_BIT];
            end
            if (FlagW[0]) begin
                r_flags[C_BIT] <= ALUFlags[C_BIT];
                r_flags[V_BIT] <= ALUFlags[V_BIT];
            end
        end
    end

`ifdef COND_STATS_EN
    logic [STAT_W-1:0] r_exec_cnt;
    logic [STAT_W-1:0] r_squash_cnt;
    logic              w_squash;

    // Squashed = live but failed its condition; flushed slots are not counted.
    assign w_squash = ~Stall & w_live & ~w_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_commit && (r_exec_cnt != {STAT_W{1'b1}})) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end
            if (w_squash && (r_squash_cnt != {STAT_W{1'b1}})) begin
                r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign exec_cnt   = r_exec_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule : cond_logic
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cond_logic
//  Purpose : Self-checking bench for cond_logic. A flag-register model is
//            stepped alongside the DUT and compared every falling edge;
//            directed scenarios add hand-computed literal expectations.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cond_logic;

    localparam int STAT_W = 16;

    logic       clk;
    logic       rst_n;
    logic       InstrValid;
    logic       Stall;
    logic       Flush;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef COND_STATS_EN
    logic [STAT_W-1:0] exec_cnt;
    logic [STAT_W-1:0] squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cond_logic #(.STAT_W(STAT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstrValid (InstrValid),
        .Stall      (Stall),
        .Flush      (Flush),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
        .Flags      (Flags)
`ifdef COND_STATS_EN
        ,
        .exec_cnt   (exec_cnt),
        .squash_cnt (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Condition truth table written straight from the mnemonic meanings.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0] m_flags;
    int unsigned m_exec;
    int unsigned m_squash;

    function automatic bit m_live();
        return InstrValid && !Flush;
    endfunction

    function automatic bit m_ce();
        return m_live() && cond_holds(Cond, m_flags);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags  = 4'b0000;
            m_exec   = 0;
            m_squash = 0;
        end else if (!Stall) begin
            if (m_ce()) begin
                if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
                if (m_exec < (2**STAT_W) - 1) m_exec++;
            end else if (m_live()) begin
                if (m_squash < (2**STAT_W) - 1) m_squash++;
            end
        end
    end

    // One compare process, every falling edge.
    always @(negedge clk) begin
        chk("m_flags",   {28'd0, Flags},    {28'd0, m_flags});
        chk("m_condex",  {31'd0, CondEx},   {31'd0, m_ce()});
        chk("m_pcsrc",   {31'd0, PCSrc},    {31'd0, PCS && m_ce()});
        chk("m_regwrite",{31'd0, RegWrite}, {31'd0, RegW && !NoWrite && m_ce()});
        chk("m_memwrite",{31'd0, MemWrite}, {31'd0, MemW && m_ce()});
`ifdef COND_STATS_EN
        chk("m_exec",    32'(exec_cnt),     m_exec);
        chk("m_squash",  32'(squash_cnt),   m_squash);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic st, input logic fl,
                         input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                         input logic pcs, input logic rw, input logic mw, input logic nw);
        @(posedge clk);
        #1;
        InstrValid = v;  Stall = st;  Flush = fl;
        Cond = c;  ALUFlags = af;  FlagW = fw;
        PCS = pcs;  RegW = rw;  MemW = mw;  NoWrite = nw;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        InstrValid = 1'b1; Stall = 1'b0; Flush = 1'b0;
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b1; MemW = 1'b0; NoWrite = 1'b0;
        #2;
        // Reset then EQ: Z clear so EQ fails.
        chk("rst_flags",    {28'd0, Flags},    32'h0);
        chk("rst_eq_condex",{31'd0, CondEx},   32'h0);
        chk("rst_eq_regw",  {31'd0, RegWrite}, 32'h0);
        #10 rst_n = 1'b1;

        // Flag write then use.
        drive(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        chk("al_condex",    {31'd0, CondEx},   32'h1);
        drive(1, 0, 0, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 0);
        chk("wr_use_flags", {28'd0, Flags},    32'h4);
        chk("wr_use_condex",{31'd0, CondEx},   32'h1);
        chk("wr_use_regw",  {31'd0, RegWrite}, 32'h1);

        // Partial write of N,Z only.
        drive(1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
        drive(1, 0, 0, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
        chk("part_before",  {28'd0, Flags},    32'hF);
        idle();
        chk("part_after",   {28'd0, Flags},    32'h3);

        // Failed condition must not update flags.
        drive(1, 0, 0, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0);
        drive(1, 0, 0, 4'h0, 4'b1111, 2'b11, 0, 0, 1, 0);
        chk("fail_flags0",  {28'd0, Flags},    32'h0);
        chk("fail_condex",  {31'd0, CondEx},   32'h0);
        chk("fail_memw",    {31'd0, MemWrite}, 32'h0);
        idle();
        chk("fail_hold",    {28'd0, Flags},    32'h0);

        // Stall holds flags, outputs stay combinational.
        drive(1, 1, 0, 4'hE, 4'b1010, 2'b11, 0, 0, 0, 0);
        chk("stall_condex", {31'd0, CondEx},   32'h1);
        idle();
        chk("stall_hold",   {28'd0, Flags},    32'h0);

        // Flush squashes; flush+stall too.
        drive(1, 0, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        chk("flush_pcsrc",  {31'd0, PCSrc},    32'h0);
        chk("flush_condex", {31'd0, CondEx},   32'h0);
        drive(1, 1, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        chk("fs_regw",      {31'd0, RegWrite}, 32'h0);
        idle();
        chk("flush_hold",   {28'd0, Flags},    32'h0);

        // CMP-type: no register write but flags update; then reserved code.
        drive(1, 0, 0, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 1);
        chk("cmp_regw",     {31'd0, RegWrite}, 32'h0);
        chk("cmp_condex",   {31'd0, CondEx},   32'h1);
        drive(1, 0, 0, 4'hF, 4'b0000, 2'b00, 0, 1, 0, 0);
        chk("cmp_flags",    {28'd0, Flags},    32'h6);
        chk("nv_condex",    {31'd0, CondEx},   32'h0);
        idle();

        // Back-to-back flag setters: second sees the first's result.
        drive(1, 0, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
        drive(1, 0, 0, 4'hA, 4'b0100, 2'b11, 0, 0, 0, 0);
        chk("b2b_flags1",   {28'd0, Flags},    32'h9);
        chk("b2b_ge",       {31'd0, CondEx},   32'h1);
        drive(1, 0, 0, 4'hB, 4'b1111, 2'b11, 0, 0, 0, 0);
        chk("b2b_flags2",   {28'd0, Flags},    32'h4);
        chk("b2b_lt",       {31'd0, CondEx},   32'h0);
        idle();
        chk("b2b_hold",     {28'd0, Flags},    32'h4);

        // Every condition against every flag value (model-checked).
        for (int f = 0; f < 16; f++) begin
            drive(1, 0, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                drive(1, 0, 0, 4'(c), 4'h0, 2'b00, 1, 1, 1, 0);
            end
        end

        // Asynchronous reset mid-instruction.
        drive(1, 0, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
        drive(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
        chk("pre_rst_flags",{28'd0, Flags},    32'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_flags",{28'd0, Flags},    32'h0);
        chk("mid_rst_regw", {31'd0, RegWrite}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cond_logic
`default_nettype wire

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage between decode/ALU and the register file, memory and PC mux of the ARM-subset processor.
- Holds the architectural NZCV flag register and evaluates the instruction's Cond field against the stored flags, using the condcheck sub-module.
- Gates the PCSrc, RegWrite and MemWrite write enables.
- Commits the new ALU flags under FlagW control, with stall and flush support.

Parameters:
- STAT_W, 16, width of the saturating statistics counters; used only when COND_STATS_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- InstrValid  in  1  current instruction is valid.
- Stall  in  1  hold all state; outputs still combinational.
- Flush  in  1  squash the current instruction; no flag update, all enables 0.
- Cond  in  4  instruction condition field, ARM encoding.
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction; suppresses RegWrite.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- CondEx  out  1  condition passed for a live instruction.
- Flags  out  4  stored {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n=0): Flags=4'b0000. All outputs are combinational from Flags, so with InstrValid=0 the enables read 0.
- live = InstrValid & ~Flush.
- CondEx = live & condcheck(Cond, Flags).
  - Flags here are the stored flags, never ALUFlags; zero-cycle evaluation.
- Condition encodings:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 (reserved) 0.
- Gated enables:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & ~NoWrite & CondEx.
  - MemWrite = MemW & CondEx.
- Flag update at posedge, when ~Stall & CondEx:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Unwritten halves hold their value.
- Boundary conditions:
  - Stall=1 wins over everything: Flags hold, even with FlagW=11 and a passing condition.
  - Flush and Stall together: no update, enables 0.
  - A failed condition never updates flags, even with FlagW set (ARM semantics).
  - Back-to-back flag-setting instructions: the second one's condition sees the first one's result (one-cycle write-then-read through the register).
  - rst_n asserted mid-instruction: Flags clear immediately; outputs follow combinationally.

Optional Feature:
- Macro: COND_STATS_EN.
- When defined, adds two STAT_W-bit saturating counters, exec_cnt and squash_cnt, and two output ports of the same names.
  - exec_cnt increments on ~Stall & CondEx.
  - squash_cnt increments on ~Stall & live & ~CondEx.
  - Both hold at all-ones, reset to 0, and do not count while flushed.
- When undefined: no counters and no extra ports; the block is otherwise identical.

Decomposition:
- Package cond_pkg:
  - cond_e enum of the 16 condition codes.
  - Flag bit index constants: N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
  - flags_t typedef (4-bit).
- Sub-module: instantiate the existing condcheck for evaluation. The flag register and gating live in cond_logic.

Test Plan:
- Reset then EQ: rst_n=0→1, Cond=0000, InstrValid=1, RegW=1 → CondEx=0, RegWrite=0, Flags=0000.
- Flag write then use: cycle 1 runs AL, FlagW=11, ALUFlags=0100; cycle 2 runs EQ with RegW=1 → Flags=0100, CondEx=1, RegWrite=1.
- Partial write: Flags=1111, FlagW=10, ALUFlags=0000, AL → Flags=0011.
- Failed condition with FlagW: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1111 → CondEx=0, Flags remain 0000, MemWrite=0 with MemW=1.
- Stall and Flush:
  - Stall=1, AL, FlagW=11, ALUFlags=1010 → Flags unchanged.
  - Flush=1, AL, PCS=1 → PCSrc=0.
- CMP and reserved code:
  - AL, RegW=1, NoWrite=1, FlagW=11 → RegWrite=0, flags update.
  - Cond=1111 → CondEx=0.
  - With COND_STATS_EN, squash_cnt increments by 1.
